// File: rtl/pixel_write_packer_if.sv
// Pixel input stream and RAM write-slot signals of the pixel write packer.
// master drives pixels and accepts write phases; slave is the packer.
interface pixel_write_packer_if #(
  parameter int PIXEL_BITS           = 2,
  parameter int LOG2_PIXELS_PER_WORD = 3
);
  logic                            pix_valid;
  logic                            pix_ready;
  logic [15:0]                     pix_addr;
  logic [LOG2_PIXELS_PER_WORD-1:0] pix_pos;
  logic [PIXEL_BITS-1:0]           pix_data;
  logic                            flush;
  logic                            write_en;
  logic                            write_mode_data;
  logic [15:0]                     w_addr;
  logic [15:0]                     w_data;
  logic                            write_accepted;
  logic                            idle;

  modport master (
    output pix_valid, pix_addr, pix_pos, pix_data, flush, write_accepted,
    input  pix_ready, write_en, write_mode_data, w_addr, w_data, idle
  );

  modport slave (
    input  pix_valid, pix_addr, pix_pos, pix_data, flush, write_accepted,
    output pix_ready, write_en, write_mode_data, w_addr, w_data, idle
  );
endinterface

// File: rtl/pixel_write_packer.sv
// Generic FIFO plus the pixel-to-word packer feeding the RAM write-slot mux.

// Generic single-clock FIFO with a zeroed head when empty.
// Latency: a push is visible at the head the following cycle.
// Backpressure: push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign push_ok  = push_vld && !full;
  assign pop_ok   = pop_vld && !empty;
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end
endmodule

// Packs 2-bit pixels into 16-bit words, emitted as address then data phase.
// Latency: a word completed in cycle t is presented at the head in cycle t+1.
// Backpressure: pix_ready drops while the word FIFO is full or a push is pending.
module pixel_write_packer #(
  parameter int PIXEL_BITS           = 2,
  parameter int LOG2_PIXELS_PER_WORD = 3,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  pixel_write_packer_if.slave      bus
);
  localparam int SHW = $clog2(16);
  localparam logic [15:0] PIX_MASK = 16'((1 << PIXEL_BITS) - 1);
  localparam logic [LOG2_PIXELS_PER_WORD-1:0] LAST_POS = '1;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } word_t;

  typedef enum logic {
    ST_ADDR = 1'b0,
    ST_DATA = 1'b1
  } seq_state_t;

  logic [15:0] acc_addr, acc_addr_nxt;
  logic [15:0] acc_data, acc_data_nxt;
  logic        acc_nonempty, acc_nonempty_nxt;
  logic        pending, pending_nxt;

  logic           accept;
  logic [SHW-1:0] shamt;
  logic [15:0]    pix_word;
  logic [15:0]    pix_mask;
  logic [15:0]    merged;
  logic           push_vld;
  word_t          push_word;
  word_t          head;
  logic           fifo_empty;
  logic           fifo_full;
  logic           pop_vld;
  seq_state_t     state, state_nxt;

  assign accept   = bus.pix_valid && bus.pix_ready;
  assign shamt    = SHW'(bus.pix_pos * PIXEL_BITS);
  assign pix_word = 16'(bus.pix_data) << shamt;
  assign pix_mask = PIX_MASK << shamt;

  assign bus.pix_ready = !fifo_full && !pending;
  assign bus.idle      = fifo_empty && !acc_nonempty && !pending;
  assign bus.w_addr    = head.addr;
  assign bus.w_data    = head.data;

  // Accumulator: at most one push per cycle; a pending word has priority.
  always_comb begin
    acc_addr_nxt     = acc_addr;
    acc_data_nxt     = acc_data;
    acc_nonempty_nxt = acc_nonempty;
    pending_nxt      = pending;
    push_vld         = 1'b0;
    push_word        = '{addr: acc_addr, data: acc_data};
    merged           = (acc_data & ~pix_mask) | pix_word;

    if (pending) begin
      if (!fifo_full) begin
        push_vld         = 1'b1;
        acc_addr_nxt     = '0;
        acc_data_nxt     = '0;
        acc_nonempty_nxt = 1'b0;
        pending_nxt      = 1'b0;
      end
    end else if (accept) begin
      if (!acc_nonempty || bus.pix_addr == acc_addr) begin
        if (bus.pix_pos == LAST_POS) begin
          push_vld         = 1'b1;
          push_word        = '{addr: bus.pix_addr, data: merged};
          acc_addr_nxt     = '0;
          acc_data_nxt     = '0;
          acc_nonempty_nxt = 1'b0;
        end else begin
          acc_addr_nxt     = bus.pix_addr;
          acc_data_nxt     = merged;
          acc_nonempty_nxt = 1'b1;
        end
      end else begin
        // Address change: retire the old word, restart with only the new pixel.
        push_vld         = 1'b1;
        acc_addr_nxt     = bus.pix_addr;
        acc_data_nxt     = pix_word;
        acc_nonempty_nxt = 1'b1;
        pending_nxt      = (bus.pix_pos == LAST_POS);
      end
    end

    if (bus.flush && acc_nonempty_nxt) pending_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_addr     <= '0;
      acc_data     <= '0;
      acc_nonempty <= 1'b0;
      pending      <= 1'b0;
    end else begin
      acc_addr     <= acc_addr_nxt;
      acc_data     <= acc_data_nxt;
      acc_nonempty <= acc_nonempty_nxt;
      pending      <= pending_nxt;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push_vld (push_vld),
    .push_dat (push_word),
    .pop_vld  (pop_vld),
    .head_dat (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_ADDR;
    else        state <= state_nxt;
  end

  // Accepts seen with an empty FIFO leave the sequencer in ST_ADDR.
  always_comb begin
    state_nxt           = state;
    pop_vld             = 1'b0;
    bus.write_en        = !fifo_empty;
    bus.write_mode_data = (state == ST_DATA);
    case (state)
      ST_ADDR: begin
        if (!fifo_empty && bus.write_accepted) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (bus.write_accepted) begin
          pop_vld   = 1'b1;
          state_nxt = ST_ADDR;
        end
      end
      default: state_nxt = ST_ADDR;
    endcase
  end
endmodule

// File: doc/pixel_write_packer.md
# pixel_write_packer

Packs the 2-bit pixel stream from the Julia iteration core into 16-bit RAM words and sequences each word as an address phase followed by a data phase. It sits directly upstream of the RAM-emulator transmit mux: its `write_en` / `write_mode_data` / `w_addr` / `w_data` / `write_accepted` port set plugs straight into the top level's write-slot logic. It decouples per-pixel production from the one-phase-per-read-slot write bandwidth through a small word FIFO.

## Interface
Parameters:
- `PIXEL_BITS`, 2: bits per pixel.
- `LOG2_PIXELS_PER_WORD`, 3: log2 of pixels per 16-bit word; must satisfy `PIXEL_BITS << LOG2_PIXELS_PER_WORD == 16`.
- `FIFO_DEPTH`, 4: number of completed-word entries (address + data); a power of 2 and at least 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `pix_valid` in 1: an input pixel is presented.
- `pix_ready` out 1: the packer accepts the pixel this cycle.
- `pix_addr` in 16: word address of the pixel.
- `pix_pos` in `LOG2_PIXELS_PER_WORD`: pixel slot within the word.
- `pix_data` in `PIXEL_BITS`: pixel value.
- `flush` in 1: single-cycle pulse; forces out a partially filled word.
- `write_en` out 1: a write phase is pending.
- `write_mode_data` out 1: 0 = address phase, 1 = data phase.
- `w_addr` out 16: word address of the FIFO head.
- `w_data` out 16: word data of the FIFO head.
- `write_accepted` in 1: the current phase is consumed this cycle.
- `idle` out 1: the FIFO is empty, the accumulator is empty and nothing is pending.

## Operation
- **Slot placement.** Slot p occupies bits `[(p+1)*PIXEL_BITS-1 -: PIXEL_BITS]`, so slot 0 is in the LSBs.
- **Accumulator.** The accumulator holds `acc_addr`, `acc_data`, `acc_nonempty` and `pending`.
- **Acceptance.** A pixel is accepted when `pix_valid && pix_ready`, with `pix_ready = !fifo_full && !pending`. Both terms are registered state, so `pix_ready` has no combinational path from the inputs.
- **Accepted pixel, accumulator empty or `pix_addr == acc_addr`.** The pixel is merged into `acc_data`.
  - If `pix_pos == 2**LOG2_PIXELS_PER_WORD - 1`, the merged word is pushed the same cycle and the accumulator is cleared.
- **Accepted pixel, accumulator non-empty and `pix_addr != acc_addr`.** The old word is pushed. The accumulator restarts with the new pixel only, and unwritten slots are 0.
  - If the new pixel is also in the last slot, set `pending`; the word is pushed on a later cycle.
- **Flush.** `flush` with the accumulator non-empty sets `pending`. `flush` with the accumulator empty is a no-op.
- **Push limit.** At most one push per cycle.
  - When `pending` is set, the accumulator is pushed on the first cycle the FIFO is not full, then cleared, and `pending` is cleared.
  - No pixel is accepted while `pending` is set.
- **Partial words.** Partially written words are pushed with unwritten slots equal to 0. Rewriting the same slot before completion overwrites it.
- **Output sequencer.** States are ADDR and DATA.
  - `write_en = !fifo_empty`.
  - `write_mode_data` is 0 in ADDR and 1 in DATA.
  - ADDR + `write_accepted` → DATA.
  - DATA + `write_accepted` → pop the head, go to ADDR.
  - `write_accepted` while `write_en == 0` is ignored.
- **Output stability.** `w_addr` and `w_data` come from the FIFO head and are 0 when the FIFO is empty. They hold stable from the push until the data phase is accepted.

## Timing
- **Reset values.**
  - `write_en` = 0, `write_mode_data` = 0, `w_addr` = 0, `w_data` = 0.
  - `pix_ready` = 1, `idle` = 1.
  - FIFO empty, accumulator cleared, sequencer in ADDR.
- **Reset mid-operation.** Reset discards the FIFO contents, the accumulator, `pending`, and any half-sent word.
- **Latency.** A word completed by the pixel accepted in cycle t is at the head (when the FIFO was empty) with `write_en` = 1 and `write_mode_data` = 0 in cycle t+1.
- **Phase timing.**
  - An address phase accepted in cycle a gives `write_mode_data` = 1 from cycle a+1.
  - A data phase accepted in cycle d pops at the end of cycle d. The next entry's address phase is presented from cycle d+1.
- **Full FIFO with a simultaneous pop.** No push happens that cycle, because `pix_ready` uses the registered count. The push happens the next cycle.
- **`flush` coinciding with an accepted pixel.** The pixel is merged first, then the flush rule is applied to the resulting accumulator.
- **Idle.** `idle` is registered-state combinational and goes to 1 in the cycle after the last pop with nothing pending.

## Test plan
- **Full word.** Pixels at addr 0x0010, pos 0..7, data 3,2,1,0,3,2,1,0; `write_accepted` tied to 1 → address phase `w_addr` = 0x0010 at mode 0, then `w_data` = 0x1B1B at mode 1. `write_en` is high for exactly 2 cycles.
- **Address change and flush.** Addr 0x0020, pos 0..2, data 1; then addr 0x0021, pos 0, data 2; then `flush` → word 0x0020/0x0015 is written, then word 0x0021/0x0002 is written. `idle` returns to 1.
- **Address change into the last slot.** Addr 0x0030, pos 0, data 3; then addr 0x0031, pos 7, data 2 → `pix_ready` is low for at least 1 cycle. Words 0x0030/0x0003 and 0x0031/0x8000 are emitted in that order.
- **Back-pressure.** `write_accepted` held at 0 while 5 full words are supplied → `pix_ready` drops after 4 pushes. Mode stays 0 and `w_addr` stays stable. Releasing `write_accepted` drains all 5 words in order with no loss.
- **Spurious accepts.** `write_accepted` pulsed while `write_en` = 0 → no state change; the first later word still starts with an address phase.
- **Async reset.** Reset asserted during a DATA phase with 2 words queued → all outputs reach their reset values immediately. After release, a new single word is emitted normally.
